// File: rtl/sort_pkg.sv
// Shared constants for the four-element pipelined sorter.
package sort_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int N_STAGES  = 3;
  localparam int N_LANES   = 4;
endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange: lo = min(a,b), hi = max(a,b).
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic swap;

  // Strict compare: equal operands pass through in their original order.
  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

// File: rtl/sort4_pipeline.sv
// Three-stage pipelined five-comparator sorting network, ascending order.
// Free-running datapath: a new group every clock, result three edges later.
module sort4_pipeline
  import sort_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3
);
  logic [WIDTH-1:0] s1_d [N_LANES];
  logic [WIDTH-1:0] s1_q [N_LANES];
  logic [WIDTH-1:0] s2_d [N_LANES];
  logic [WIDTH-1:0] s2_q [N_LANES];
  logic [WIDTH-1:0] s3_d [N_LANES];
  logic [WIDTH-1:0] s3_q [N_LANES];

  // Stage 1: sort each input pair.
  cmp_swap #(.WIDTH(WIDTH)) u_c10 (.a(x0), .b(x1), .lo(s1_d[0]), .hi(s1_d[1]));
  cmp_swap #(.WIDTH(WIDTH)) u_c11 (.a(x2), .b(x3), .lo(s1_d[2]), .hi(s1_d[3]));

  // Stage 2: lane 0 becomes the global min, lane 3 the global max.
  cmp_swap #(.WIDTH(WIDTH)) u_c20 (.a(s1_q[0]), .b(s1_q[2]), .lo(s2_d[0]), .hi(s2_d[2]));
  cmp_swap #(.WIDTH(WIDTH)) u_c21 (.a(s1_q[1]), .b(s1_q[3]), .lo(s2_d[1]), .hi(s2_d[3]));

  // Stage 3: only the middle pair can still be out of order.
  cmp_swap #(.WIDTH(WIDTH)) u_c30 (.a(s2_q[1]), .b(s2_q[2]), .lo(s3_d[1]), .hi(s3_d[2]));
  assign s3_d[0] = s2_q[0];
  assign s3_d[3] = s2_q[3];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
        s3_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        s1_q[i] <= s1_d[i];
        s2_q[i] <= s2_d[i];
        s3_q[i] <= s3_d[i];
      end
    end
  end

  assign y0 = s3_q[0];
  assign y1 = s3_q[1];
  assign y2 = s3_q[2];
  assign y3 = s3_q[3];
endmodule

// File: tb/tb_sort4_pipeline.sv
// Bench for sort4_pipeline: sorted-group delay-line model, literal vectors, random stream.
module tb_sort4_pipeline;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] x0, x1, x2, x3;
  logic [W-1:0] y0, y1, y2, y3;

  int total;
  int bad;

  logic [4*W-1:0] pipe [3];
  logic           seen_reset;
  logic [4*W-1:0] lit_in  [9];
  logic [4*W-1:0] lit_out [9];

  sort4_pipeline #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference sort: plain bubble sort of the four values, packed {e0,e1,e2,e3}.
  function automatic logic [4*W-1:0] sort_group(input logic [4*W-1:0] g);
    logic [W-1:0] v [4];
    logic [W-1:0] t;
    v[0] = g[4*W-1:3*W];
    v[1] = g[3*W-1:2*W];
    v[2] = g[2*W-1:W];
    v[3] = g[W-1:0];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic check(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [4*W-1:0] g);
    x0 = g[4*W-1:3*W];
    x1 = g[3*W-1:2*W];
    x2 = g[2*W-1:W];
    x3 = g[W-1:0];
  endtask

  function automatic logic [4*W-1:0] rand_group();
    logic [4*W-1:0] g;
    bit narrow;
    narrow = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 4; i++)
      g[i*W +: W] = narrow ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
    return g;
  endfunction

  // Model: a group sampled at an edge is visible, sorted, after the second following edge.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      seen_reset = 1'b1;
      for (int i = 0; i < 3; i++) pipe[i] = '0;
    end else if (seen_reset) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = sort_group({x0, x1, x2, x3});
    end
  end

  // Scoreboard compare on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (seen_reset) begin
      check("model", {y0, y1, y2, y3}, pipe[2]);
      check("order", {31'd0, (y0 <= y1) && (y1 <= y2) && (y2 <= y3)}, 32'd1);
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    seen_reset = 1'b0;
    rst        = 1'b0;
    drive(rand_group());

    lit_in  = '{{8'd38, 8'd94, 8'd61, 8'd50}, {8'd24, 8'd15, 8'd82, 8'd65},
                {8'd89, 8'd20, 8'd63, 8'd51}, {8'd71, 8'd42, 8'd90, 8'd89},
                {8'd255,8'd128,8'd1,  8'd0 }, {8'd11, 8'd22, 8'd33, 8'd44},
                {8'd23, 8'd60, 8'd30, 8'd11}, {8'd30, 8'd30, 8'd30, 8'd30},
                {8'd50, 8'd13, 8'd50, 8'd13}};
    lit_out = '{{8'd38, 8'd50, 8'd61, 8'd94}, {8'd15, 8'd24, 8'd65, 8'd82},
                {8'd20, 8'd51, 8'd63, 8'd89}, {8'd42, 8'd71, 8'd89, 8'd90},
                {8'd0,  8'd1,  8'd128,8'd255}, {8'd11, 8'd22, 8'd33, 8'd44},
                {8'd11, 8'd23, 8'd30, 8'd60}, {8'd30, 8'd30, 8'd30, 8'd30},
                {8'd13, 8'd13, 8'd50, 8'd50}};

    // Pin the reference sort against hand-computed results.
    for (int i = 0; i < 9; i++) check("model_pin", sort_group(lit_in[i]), lit_out[i]);

    // Reset held for two edges.
    @(negedge clk);
    check("reset_y", {y0, y1, y2, y3}, '0);
    @(negedge clk);
    check("reset_y", {y0, y1, y2, y3}, '0);
    rst = 1'b1;

    // Directed groups back to back; group j shows up on the falling edge where j+3 is driven.
    for (int j = 0; j < 12; j++) begin
      if (j < 3) check("fill_zero", {y0, y1, y2, y3}, '0);
      else       check("directed", {y0, y1, y2, y3}, lit_out[j-3]);
      if (j < 9) drive(lit_in[j]);
      else       drive(rand_group());
      @(negedge clk);
    end

    // Random stream with a one-edge reset while groups are in flight.
    for (int c = 0; c < 60; c++) begin
      if (c >= 31 && c <= 33) check("midrst_zero", {y0, y1, y2, y3}, '0);
      rst = (c == 30) ? 1'b0 : 1'b1;
      drive(rand_group());
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
